adpcm_decoder: RTL

//  Decoder for the 4-bit IMA-ADPCM code stream the on-chip compressor produces.

---
 rtl/adpcm_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adpcm_decoder.sv
// IMA-ADPCM decoder: takes one 4-bit code per input handshake and produces one
// 16-bit signed PCM sample per output handshake.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   block_enable_i 0 holds the decoder idle and reloads the initial predictor/index
//   in_valid_i     in_code_i is valid
//   in_code_i      ADPCM code, [3] sign, [2:0] magnitude
//   in_ready_o     decoder accepts a code this cycle (IDLE only)
//   out_valid_o    out_pcm_o is valid; held until out_ready_i
//   out_pcm_o      decoded signed PCM sample
//   out_ready_i    downstream accepts out_pcm_o
module adpcm_decoder #(
  parameter logic signed [15:0] INIT_PREDICTOR = 16'sd0,
  parameter int unsigned        INIT_INDEX     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        block_enable_i,
  input  logic        in_valid_i,
  input  logic [3:0]  in_code_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [15:0] out_pcm_o,
  input  logic        out_ready_i
);

  typedef enum logic [1:0] {StIdle, StCalc, StUpd, StOut} state_e;

  localparam int unsigned StepTab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
    12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  state_e             state_q, state_d;
  logic [3:0]         code_q, code_d;
  logic [16:0]        diff_q, diff_d;
  logic signed [15:0] pred_q, pred_d;
  logic [6:0]         index_q, index_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_pcm_q, out_pcm_d;

  logic [16:0]        step;
  logic [16:0]        diff_calc;
  logic signed [17:0] pred_ext, diff_ext, sum;
  logic signed [15:0] pcm_sat;
  logic signed [7:0]  idx_adj, idx_sum;
  logic [6:0]         idx_clamped;

  // Magnitude to difference, using the shifted partial sums of the step size.
  always_comb begin
    step      = 17'(StepTab[index_q]);
    diff_calc = (step >> 3)
              + (code_q[2] ? step        : 17'd0)
              + (code_q[1] ? (step >> 1) : 17'd0)
              + (code_q[0] ? (step >> 2) : 17'd0);
  end

  // 18 bits holds predictor +/- the largest difference without overflow.
  always_comb begin
    pred_ext = {{2{pred_q[15]}}, pred_q};
    diff_ext = {1'b0, diff_q};
    sum      = code_q[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
    if (sum > 18'sd32767) begin
      pcm_sat = 16'sh7fff;
    end else if (sum < -18'sd32768) begin
      pcm_sat = 16'sh8000;
    end else begin
      pcm_sat = sum[15:0];
    end
  end

  always_comb begin
    case (code_q[2:0])
      3'd4:    idx_adj = 8'sd2;
      3'd5:    idx_adj = 8'sd4;
      3'd6:    idx_adj = 8'sd6;
      3'd7:    idx_adj = 8'sd8;
      default: idx_adj = -8'sd1;
    endcase
    idx_sum = $signed({1'b0, index_q}) + idx_adj;
    if (idx_sum < 8'sd0) begin
      idx_clamped = 7'd0;
    end else if (idx_sum > 8'sd88) begin
      idx_clamped = 7'd88;
    end else begin
      idx_clamped = idx_sum[6:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    diff_d      = diff_q;
    pred_d      = pred_q;
    index_d     = index_q;
    out_valid_d = out_valid_q;
    out_pcm_d   = out_pcm_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          code_d  = in_code_i;
          state_d = StCalc;
        end
      end
      StCalc: begin
        diff_d  = diff_calc;
        state_d = StUpd;
      end
      StUpd: begin
        pred_d      = pcm_sat;
        out_pcm_d   = pcm_sat;
        index_d     = idx_clamped;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Disable behaves like reset and wins over any handshake in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i || !block_enable_i) begin
      state_q     <= StIdle;
      code_q      <= 4'd0;
      diff_q      <= 17'd0;
      pred_q      <= INIT_PREDICTOR;
      index_q     <= 7'(INIT_INDEX);
      out_valid_q <= 1'b0;
      out_pcm_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      diff_q      <= diff_d;
      pred_q      <= pred_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      out_pcm_q   <= out_pcm_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle) && block_enable_i && !rst_i;
  assign out_valid_o = out_valid_q;
  assign out_pcm_o   = out_pcm_q;

endmodule
